ps2_command_parser: RTL and testbench

- Downstream consumer of the PS/2 line assembler.
- Takes a completed 32-character ASCII line (256 bits, first character in bits [255:248]) and the line-ready strobe.
- Scans the line one character per clock and decodes launch commands.
- Commits the resulting velocity/angle registers and issues a one-cycle fire pulse to the missile/physics logic.

---
 rtl/ps2_command_parser_if.sv | 21 ++
 rtl/ps2_command_parser.sv | 182 ++++++++++++++++++
 tb/tb_ps2_command_parser.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_command_parser_if.sv
// Bundles the line-assembler input and the command outputs of the command parser.
interface ps2_command_parser_if;
    logic [255:0] line_content;
    logic         line_ready;
    logic [31:0]  velocity;
    logic [31:0]  angle;
    logic         fire;
    logic         cmd_valid;
    logic         cmd_error;
    logic         busy;

    modport master (
        output line_content, line_ready,
        input  velocity, angle, fire, cmd_valid, cmd_error, busy
    );

    modport slave (
        input  line_content, line_ready,
        output velocity, angle, fire, cmd_valid, cmd_error, busy
    );
endinterface

// File: rtl/ps2_command_parser.sv
// Scans a 32-character ASCII line one character per clock and decodes V/A/F
// launch commands, committing velocity/angle and pulsing fire on a clean parse.
module ps2_command_parser #(
    parameter int unsigned VEL_MAX   = 999,
    parameter int unsigned ANG_MAX   = 90,
    parameter int unsigned VEL_RESET = 10,
    parameter int unsigned ANG_RESET = 45
) (
    input logic                  clock_i,
    input logic                  reset_i,
    ps2_command_parser_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;
    typedef enum logic [1:0] {FldNone, FldVel, FldAng, FldFire} field_e;

    // Per-line working state, cleared at the start of every line.
    typedef struct packed {
        logic [15:0] acc;
        logic [5:0]  ndigits;
        field_e      field;
        logic [15:0] vel;
        logic [15:0] ang;
        logic        has_v;
        logic        has_a;
        logic        has_f;
        logic        err;
    } scratch_t;

    localparam logic [15:0] VelMax16 = 16'(VEL_MAX);
    localparam logic [15:0] AngMax16 = 16'(ANG_MAX);

    state_e       state_q, state_d;
    logic         prev_q;
    logic [255:0] buf_q, buf_d;
    logic [4:0]   idx_q, idx_d;
    scratch_t     sc_q, sc_d;
    logic [15:0]  velocity_q, velocity_d;
    logic [15:0]  angle_q, angle_d;
    logic         fire_q, fire_d;
    logic         valid_q, valid_d;
    logic         error_q, error_d;

    logic         start;
    scratch_t     s;
    logic         fin;
    logic [7:0]   ch;
    logic [19:0]  prod;

    // An open V/A field is clamped into its result; a field with no digits is an error.
    function automatic scratch_t close_field(scratch_t in);
        scratch_t r;
        r = in;
        if (in.field == FldVel || in.field == FldAng) begin
            if (in.ndigits == '0) r.err = 1'b1;
            if (in.field == FldVel) begin
                r.vel   = (in.acc > VelMax16) ? VelMax16 : in.acc;
                r.has_v = 1'b1;
            end else begin
                r.ang   = (in.acc > AngMax16) ? AngMax16 : in.acc;
                r.has_a = 1'b1;
            end
        end
        r.field = FldNone;
        return r;
    endfunction

    assign start = bus.line_ready & ~prev_q;

    // Next-state, character decode and commit logic.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        sc_d       = sc_q;
        velocity_d = velocity_q;
        angle_d    = angle_q;
        fire_d     = 1'b0;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        s          = sc_q;
        fin        = 1'b0;
        ch         = buf_q[255:248];
        prod       = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    buf_d   = bus.line_content;
                    idx_d   = '0;
                    sc_d    = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (ch == 8'h56 || ch == 8'h76 || ch == 8'h41 || ch == 8'h61) begin
                    s         = close_field(s);
                    s.field   = (ch == 8'h56 || ch == 8'h76) ? FldVel : FldAng;
                    s.acc     = '0;
                    s.ndigits = '0;
                end else if (ch >= 8'h30 && ch <= 8'h39) begin
                    if (s.field == FldNone || s.field == FldFire) begin
                        s.err = 1'b1;
                    end else begin
                        prod      = 20'(s.acc) * 20'd10 + {16'b0, ch[3:0]};
                        s.acc     = (prod > 20'h0FFFF) ? 16'hFFFF : prod[15:0];
                        s.ndigits = s.ndigits + 6'd1;
                    end
                end else if (ch == 8'h46 || ch == 8'h66) begin
                    s       = close_field(s);
                    s.has_f = 1'b1;
                    s.field = FldFire;
                end else if (ch == 8'h20) begin
                    s = close_field(s);
                end else if (ch == 8'h00) begin
                    fin = 1'b1;
                end else begin
                    s.err = 1'b1;
                end

                if (idx_q == 5'd31) fin = 1'b1;

                if (fin) begin
                    s       = close_field(s);
                    state_d = StDone;
                    if (s.err) begin
                        error_d = 1'b1;
                    end else if (s.has_v || s.has_a || s.has_f) begin
                        if (s.has_v) velocity_d = s.vel;
                        if (s.has_a) angle_d = s.ang;
                        valid_d = 1'b1;
                        fire_d  = s.has_f;
                    end
                end

                sc_d  = s;
                buf_d = {buf_q[247:0], 8'h00};
                idx_d = idx_q + 5'd1;
            end
            StDone: begin
                // Edges arriving here are consumed by prev_q and never queued.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            prev_q     <= 1'b0;
            buf_q      <= '0;
            idx_q      <= '0;
            sc_q       <= '0;
            velocity_q <= 16'(VEL_RESET);
            angle_q    <= 16'(ANG_RESET);
            fire_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= bus.line_ready;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            sc_q       <= sc_d;
            velocity_q <= velocity_d;
            angle_q    <= angle_d;
            fire_q     <= fire_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign bus.velocity  = {16'b0, velocity_q};
    assign bus.angle     = {16'b0, angle_q};
    assign bus.fire      = fire_q;
    assign bus.cmd_valid = valid_q;
    assign bus.cmd_error = error_q;
    assign bus.busy      = (state_q == StScan) || (state_q == StDone);

endmodule

// File: tb/tb_ps2_command_parser.sv
// Self-checking bench for ps2_command_parser using an expected-result queue.
module tb_ps2_command_parser;

    typedef struct packed {
        bit          valid;
        bit          error;
        bit          fire;
        int unsigned vel;
        int unsigned ang;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ps2_command_parser_if bus_if ();

    ps2_command_parser dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input string s);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < 32; i++) r[255-8*i -: 8] = s[i];
        return r;
    endfunction

    // Number of characters the parser consumes: up to and including the terminator.
    function automatic int scan_len(input logic [255:0] c);
        for (int i = 0; i < 32; i++) if (c[255-8*i -: 8] == 8'h00) return i + 1;
        return 32;
    endfunction

    // Drives one line, times its pulses against the expected scan length and
    // checks the popped scoreboard entry.
    task automatic do_line(input string name, input logic [255:0] content, input exp_t e);
        int   len, pulse_cyc, idle_cyc, npulse, exp_np;
        bit   got_v, got_e, got_f;
        logic [31:0] ov, oa;
        exp_t x;
        len = scan_len(content);
        sb.push_back(e);
        pulse_cyc = -1; idle_cyc = -1; npulse = 0;
        got_v = 0; got_e = 0; got_f = 0; ov = '0; oa = '0;
        @(negedge clk);
        bus_if.line_content = content;
        bus_if.line_ready   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus_if.fire || bus_if.cmd_valid || bus_if.cmd_error) begin
                npulse++;
                pulse_cyc = i;
                got_v |= bus_if.cmd_valid;
                got_e |= bus_if.cmd_error;
                got_f |= bus_if.fire;
                ov = bus_if.velocity;
                oa = bus_if.angle;
            end
            if (i > 0 && !bus_if.busy) begin
                idle_cyc = i;
                break;
            end
        end
        if (npulse == 0) begin
            ov = bus_if.velocity;
            oa = bus_if.angle;
        end
        @(negedge clk);
        bus_if.line_ready = 1'b0;
        x = sb.pop_front();
        exp_np = (x.valid || x.error) ? 1 : 0;

        checks++;
        if (idle_cyc === -1) begin
            errors++; $display("FAIL %s timeout: busy never fell within 50 cycles", name);
        end
        checks++;
        if (got_v !== x.valid) begin
            errors++; $display("FAIL %s cmd_valid: got %0b expected %0b", name, got_v, x.valid);
        end
        checks++;
        if (got_e !== x.error) begin
            errors++; $display("FAIL %s cmd_error: got %0b expected %0b", name, got_e, x.error);
        end
        checks++;
        if (got_f !== x.fire) begin
            errors++; $display("FAIL %s fire: got %0b expected %0b", name, got_f, x.fire);
        end
        checks++;
        if (ov !== x.vel) begin
            errors++; $display("FAIL %s velocity: got %0d expected %0d", name, ov, x.vel);
        end
        checks++;
        if (oa !== x.ang) begin
            errors++; $display("FAIL %s angle: got %0d expected %0d", name, oa, x.ang);
        end
        checks++;
        if (npulse !== exp_np) begin
            errors++; $display("FAIL %s pulse_cycles: got %0d expected %0d", name, npulse, exp_np);
        end
        if (exp_np == 1) begin
            checks++;
            if (pulse_cyc !== len) begin
                errors++;
                $display("FAIL %s pulse_cycle: got %0d expected %0d", name, pulse_cyc, len);
            end
        end
        checks++;
        if (idle_cyc !== len + 1) begin
            errors++; $display("FAIL %s idle_cycle: got %0d expected %0d", name, idle_cyc, len + 1);
        end
    endtask

    // Runs for ncyc cycles; every pulse must match the head of the scoreboard.
    task automatic watch(input string name, input int ncyc, output int npulse);
        exp_t x;
        npulse = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (bus_if.fire || bus_if.cmd_valid || bus_if.cmd_error) begin
                npulse++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_pulse: got valid=%0b error=%0b fire=%0b expected none",
                             name, bus_if.cmd_valid, bus_if.cmd_error, bus_if.fire);
                end else begin
                    x = sb.pop_front();
                    if (bus_if.cmd_valid !== x.valid || bus_if.cmd_error !== x.error ||
                        bus_if.fire !== x.fire || bus_if.velocity !== x.vel ||
                        bus_if.angle !== x.ang) begin
                        errors++;
                        $display("FAIL %s result: got v=%0b e=%0b f=%0b vel=%0d ang=%0d expected v=%0b e=%0b f=%0b vel=%0d ang=%0d",
                                 name, bus_if.cmd_valid, bus_if.cmd_error, bus_if.fire,
                                 bus_if.velocity, bus_if.angle, x.valid, x.error, x.fire,
                                 x.vel, x.ang);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.line_ready   = 1'b0;
        bus_if.line_content = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_if.velocity !== 32'd10) begin
            errors++; $display("FAIL reset velocity: got %0d expected 10", bus_if.velocity);
        end
        checks++;
        if (bus_if.angle !== 32'd45) begin
            errors++; $display("FAIL reset angle: got %0d expected 45", bus_if.angle);
        end
        checks++;
        if ({bus_if.fire, bus_if.cmd_valid, bus_if.cmd_error, bus_if.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: got fire/valid/error/busy=%b expected 0000",
                     {bus_if.fire, bus_if.cmd_valid, bus_if.cmd_error, bus_if.busy});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clamp();
        do_line("a200",   mk("A200"),   '{valid: 1, error: 0, fire: 0, vel: 10,  ang: 90});
        do_line("v70000", mk("V70000"), '{valid: 1, error: 0, fire: 0, vel: 999, ang: 90});
    endtask

    task automatic test_basic();
        do_line("launch", mk("V120 A30 F"), '{valid: 1, error: 0, fire: 1, vel: 120, ang: 30});
    endtask

    task automatic test_errors();
        do_line("v12x",  mk("V12X"), '{valid: 0, error: 1, fire: 0, vel: 120, ang: 30});
        do_line("empty_v", mk("V A5"), '{valid: 0, error: 1, fire: 0, vel: 120, ang: 30});
        do_line("f3",    mk("F3"),   '{valid: 0, error: 1, fire: 0, vel: 120, ang: 30});
    endtask

    task automatic test_empty_and_full();
        string s;
        do_line("zeros", '0, '{valid: 0, error: 0, fire: 0, vel: 120, ang: 30});
        s = "V";
        for (int i = 0; i < 31; i++) s = {s, "1"};
        do_line("full32", mk(s), '{valid: 1, error: 0, fire: 0, vel: 999, ang: 30});
    endtask

    task automatic test_lowercase();
        do_line("lower", mk("a5  v7 a9"), '{valid: 1, error: 0, fire: 0, vel: 7, ang: 9});
    endtask

    task automatic test_back_to_back();
        int n;
        sb.push_back('{valid: 1, error: 0, fire: 1, vel: 5, ang: 6});
        @(negedge clk);
        bus_if.line_content = mk("V5 A6 F");
        bus_if.line_ready   = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.line_ready = 1'b0;
        @(negedge clk);
        bus_if.line_content = mk("V9 F");
        bus_if.line_ready   = 1'b1;
        watch("b2b", 40, n);
        checks++;
        if (n !== 1) begin
            errors++; $display("FAIL b2b parses: got %0d expected 1", n);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL b2b scoreboard_left: got %0d expected 0", sb.size());
        end
        @(negedge clk);
        bus_if.line_ready = 1'b0;
        @(negedge clk);
        sb.push_back('{valid: 1, error: 0, fire: 0, vel: 300, ang: 6});
        bus_if.line_content = mk("V300");
        bus_if.line_ready   = 1'b1;
        watch("held", 100, n);
        checks++;
        if (n !== 1) begin
            errors++; $display("FAIL held parses: got %0d expected 1", n);
        end
        checks++;
        if (bus_if.velocity !== 32'd300) begin
            errors++; $display("FAIL held velocity: got %0d expected 300", bus_if.velocity);
        end
        @(negedge clk);
        bus_if.line_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int n;
        @(negedge clk);
        bus_if.line_content = mk("V400 A7 F");
        bus_if.line_ready   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus_if.line_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.velocity !== 32'd10 || bus_if.angle !== 32'd45) begin
            errors++;
            $display("FAIL midreset regs: got vel=%0d ang=%0d expected vel=10 ang=45",
                     bus_if.velocity, bus_if.angle);
        end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL midreset busy: got %0b expected 0", bus_if.busy);
        end
        rst = 1'b0;
        watch("midreset", 40, n);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL midreset pulses: got %0d expected 0", n);
        end
        checks++;
        if (bus_if.velocity !== 32'd10 || bus_if.angle !== 32'd45) begin
            errors++;
            $display("FAIL midreset after: got vel=%0d ang=%0d expected vel=10 ang=45",
                     bus_if.velocity, bus_if.angle);
        end
    endtask

    initial begin
        bus_if.line_ready   = 1'b0;
        bus_if.line_content = '0;
        test_reset();
        test_clamp();
        test_basic();
        test_errors();
        test_empty_and_full();
        test_lowercase();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
